hyperram_wb_bridge: RTL

// Wishbone-classic slave that sits directly upstream of the hyperram controller core.

---
 rtl/hyperram_pkg.sv | 34 +++
 rtl/hyperram_wb_bridge.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hyperram_pkg.sv
// Shared types and constants for the HyperRAM Wishbone bridge.
// Holds the bridge FSM encoding and the config register field layout.
package hyperram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG_ACK,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    localparam int CFG_WAIT_LO = 0;
    localparam int CFG_DONE_LO = 8;
    localparam int CFG_LAT_W   = 6;
    localparam int CFG_TIMED   = 16;
    localparam int CFG_RD_W    = 17;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] wdat,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/hyperram_wb_bridge.sv
// Wishbone-classic slave feeding one HyperRAM core transaction per bus access.
// Also owns the core latency config register and a sticky timeout flag.
module hyperram_wb_bridge
    import hyperram_pkg::*;
#(
    parameter logic [31:0] ADDR_MASK    = 32'hFF00_0000,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [23:0] CFG_OFFSET   = 24'hFF_FFFC,
    parameter logic [5:0]  DEF_WAIT_LAT = 6'd6,
    parameter logic [5:0]  DEF_DONE_LAT = 6'd4,
    parameter logic [7:0]  TIMEOUT      = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        hr_transaction_begin,
    output logic        hr_write_enable,
    output logic [31:0] hr_address,
    output logic [3:0]  hr_write_mask,
    output logic [31:0] hr_data_out,
    output logic [5:0]  hr_wait_latency,
    output logic [5:0]  hr_done_latency,
    output logic        hr_timed_read,
    input  logic        hr_done,
    input  logic [31:0] hr_read_data,
    output logic        err_timeout
);

    localparam logic [31:0] CFG_RST =
        {15'b0, 1'b0, 2'b0, DEF_DONE_LAT, 2'b0, DEF_WAIT_LAT};

    state_t      state;
    state_t      state_nx;
    logic [31:0] cfg;
    logic [31:0] rdata;
    logic [7:0]  cnt;
    logic        aborted;
    logic        hit;
    logic        req;
    logic        cfg_hit;
    logic        tmo;
    logic        in_core;
    logic [31:0] cfg_rd;

    assign hit     = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
    assign req     = wbs_cyc_i & wbs_stb_i & hit;
    assign cfg_hit = (wbs_adr_i & ~ADDR_MASK) == {8'h00, CFG_OFFSET};
    assign tmo     = cnt == (TIMEOUT - 8'd1);
    assign in_core = (state == ISSUE) || (state == WAIT);
    assign cfg_rd  = {err_timeout, 14'b0, cfg[CFG_RD_W-1:0]};

    assign hr_wait_latency = cfg[CFG_WAIT_LO +: CFG_LAT_W];
    assign hr_done_latency = cfg[CFG_DONE_LO +: CFG_LAT_W];
    assign hr_timed_read   = cfg[CFG_TIMED];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req) state_nx = cfg_hit ? CFG_ACK : ISSUE;
            end
            CFG_ACK: state_nx = IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT: begin
                if (hr_done || tmo) state_nx = ACK;
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // An abandoned bus cycle still completes on the core side, but is never acked.
    always_comb begin
        wbs_ack_o            = 1'b0;
        wbs_dat_o            = 32'h0;
        hr_transaction_begin = 1'b0;
        unique case (state)
            CFG_ACK: begin
                wbs_ack_o = 1'b1;
                wbs_dat_o = cfg_rd;
            end
            ISSUE: hr_transaction_begin = 1'b1;
            ACK: begin
                if (wbs_cyc_i && !aborted) begin
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg         <= CFG_RST;
            err_timeout <= 1'b0;
        end else if (state == IDLE && req && cfg_hit) begin
            if (wbs_we_i) begin
                cfg         <= byte_merge(cfg, wbs_dat_i, wbs_sel_i);
                err_timeout <= 1'b0;
            end
        end else if (state == WAIT && !hr_done && tmo) begin
            err_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hr_write_enable <= 1'b0;
            hr_address      <= 32'h0;
            hr_write_mask   <= 4'h0;
            hr_data_out     <= 32'h0;
        end else if (state == IDLE && req && !cfg_hit) begin
            hr_write_enable <= wbs_we_i;
            hr_address      <= wbs_adr_i & ~ADDR_MASK;
            hr_write_mask   <= ~wbs_sel_i;
            hr_data_out     <= wbs_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 8'h0;
            aborted <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            if (state == IDLE && req && !cfg_hit) begin
                cnt     <= 8'h0;
                aborted <= 1'b0;
            end
            if (in_core && !wbs_cyc_i) aborted <= 1'b1;
            if (state == WAIT) begin
                cnt <= cnt + 8'd1;
                if (hr_done) begin
                    if (!hr_write_enable) rdata <= hr_read_data;
                end else if (tmo) begin
                    rdata <= TIMEOUT_DATA;
                end
            end
        end
    end

endmodule
